// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
package reorder_buffer_pkg;

  localparam int ROB_WIDTH_DEF = 4;
  localparam int DATA_W        = 32;
  localparam int REG_W         = 5;

  // Control states: FLUSH is a single-cycle recovery state after a mispredict commit.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } robState_t;

  // Redirect vector driven while no flush has happened yet.
  localparam logic [DATA_W-1:0] FLUSH_PC_RESET = '0;

  // Per-entry bookkeeping besides busy/ready/value, which are kept as flat
  // vectors so the operand lookups can index them directly.
  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic              isBranch;
    logic              mispredict;
    logic [DATA_W-1:0] target;
  } robMeta_t;

endpackage

// File: rtl/reorder_buffer_operand_lookup.sv
// Operand readiness lookup: stored entry value first, CDB bypass second.
module rob_operand_lookup
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic [2**ROB_WIDTH-1:0]             entBusy,
  input  logic [2**ROB_WIDTH-1:0]             entReady,
  input  logic [2**ROB_WIDTH-1:0][DATA_W-1:0] entValue,
  input  logic [ROB_WIDTH-1:0]                dep,
  input  logic                                cdbValid,
  input  logic [ROB_WIDTH-1:0]                cdbRobId,
  input  logic [DATA_W-1:0]                   cdbValue,
  output logic                                depReady,
  output logic [DATA_W-1:0]                   depValue
);

  // Completed entry wins; otherwise catch the result being broadcast this cycle.
  always_comb begin
    depReady = 1'b0;
    depValue = '0;
    if (entBusy[dep] && entReady[dep]) begin
      depReady = 1'b1;
      depValue = entValue[dep];
    end else if (cdbValid && (cdbRobId == dep)) begin
      depReady = 1'b1;
      depValue = cdbValue;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, complete from CDB,
// retire one entry per cycle from head, flush on a mispredicted branch.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 allocValid,
  input  logic [REG_W-1:0]     allocDest,
  input  logic                 allocIsBranch,
  output logic                 allocReady,
  output logic [ROB_WIDTH-1:0] allocRobId,
  input  logic                 cdbValid,
  input  logic [ROB_WIDTH-1:0] cdbRobId,
  input  logic [DATA_W-1:0]    cdbValue,
  input  logic                 cdbMispredict,
  input  logic [DATA_W-1:0]    cdbTarget,
  input  logic [ROB_WIDTH-1:0] rs1Dep,
  input  logic [ROB_WIDTH-1:0] rs2Dep,
  output logic                 rs1Ready,
  output logic                 rs2Ready,
  output logic [DATA_W-1:0]    rs1Value,
  output logic [DATA_W-1:0]    rs2Value,
  output logic                 regUpdateValid,
  output logic [REG_W-1:0]     regUpdateDest,
  output logic [DATA_W-1:0]    regUpdateValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId,
  output logic                 flushOut,
  output logic [DATA_W-1:0]    flushPc
);

  localparam int                 DEPTH      = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH+1)'(DEPTH);

  robState_t                   state, stateNext;
  logic [ROB_WIDTH-1:0]        head, tail;
  logic [ROB_WIDTH:0]          count;
  logic [DEPTH-1:0]            busy, ready;
  logic [DEPTH-1:0][DATA_W-1:0] value;
  robMeta_t [DEPTH-1:0]        meta;
  logic                        doAlloc, doCommit, doFlush, cdbHit;

  // Per-cycle action decode; a mispredicted branch at head turns its commit into a flush.
  always_comb begin
    doAlloc  = allocValid & allocReady;
    doCommit = (state == RUN) & busy[head] & ready[head];
    doFlush  = doCommit & meta[head].isBranch & meta[head].mispredict;
    cdbHit   = (state == RUN) & cdbValid & busy[cdbRobId];
  end

  // Control state register.
  always_ff @(posedge clockIn) begin
    if (resetIn) state <= RUN;
    else         state <= stateNext;
  end

  // Next state: FLUSH is entered on a flushing commit and always left after one cycle.
  always_comb begin
    stateNext = RUN;
    if (state == RUN && doFlush) stateNext = FLUSH;
  end

  // Issue-side outputs; a commit this cycle only frees a slot for the next cycle.
  always_comb begin
    allocReady = (count != FULL_COUNT) && (state == RUN);
    allocRobId = tail;
  end

  // Entry storage: flush wipes everything and drops same-edge alloc/CDB traffic.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      busy  <= '0;
      ready <= '0;
    end else if (doFlush) begin
      busy  <= '0;
      ready <= '0;
    end else begin
      if (cdbHit) begin
        ready[cdbRobId]            <= 1'b1;
        value[cdbRobId]            <= cdbValue;
        meta[cdbRobId].mispredict  <= cdbMispredict;
        meta[cdbRobId].target      <= cdbTarget;
      end
      if (doAlloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        meta[tail]  <= '{dest: allocDest, isBranch: allocIsBranch,
                         mispredict: 1'b0, target: '0};
      end
      // Head and tail can only coincide here when full, where alloc is refused.
      if (doCommit) busy[head] <= 1'b0;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clockIn) begin
    if (resetIn || doFlush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (doAlloc)  tail <= tail + ROB_WIDTH'(1);
      if (doCommit) head <= head + ROB_WIDTH'(1);
      case ({doAlloc, doCommit})
        2'b10:   count <= count + (ROB_WIDTH+1)'(1);
        2'b01:   count <= count - (ROB_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered commit/flush outputs; data fields hold until the next commit.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      regUpdateValid <= 1'b0;
      regUpdateDest  <= '0;
      regUpdateValue <= '0;
      regUpdateRobId <= '0;
      flushOut       <= 1'b0;
      flushPc        <= FLUSH_PC_RESET;
    end else begin
      regUpdateValid <= doCommit && (meta[head].dest != '0);
      flushOut       <= doFlush;
      if (doCommit) begin
        regUpdateDest  <= meta[head].dest;
        regUpdateValue <= value[head];
        regUpdateRobId <= head;
      end
      if (doFlush) flushPc <= meta[head].target;
    end
  end

  rob_operand_lookup #(.ROB_WIDTH(ROB_WIDTH)) uRs1Lookup (
    .entBusy  (busy),
    .entReady (ready),
    .entValue (value),
    .dep      (rs1Dep),
    .cdbValid (cdbValid),
    .cdbRobId (cdbRobId),
    .cdbValue (cdbValue),
    .depReady (rs1Ready),
    .depValue (rs1Value)
  );

  rob_operand_lookup #(.ROB_WIDTH(ROB_WIDTH)) uRs2Lookup (
    .entBusy  (busy),
    .entReady (ready),
    .entValue (value),
    .dep      (rs2Dep),
    .cdbValid (cdbValid),
    .cdbRobId (cdbRobId),
    .cdbValue (cdbValue),
    .depReady (rs2Ready),
    .depValue (rs2Value)
  );

endmodule
